// File: rtl/vip_frame_capture.sv
// One-shot binary frame grabber: packs VIP pixels into PACK_W-bit words and streams {addr,data} out through a
// small FIFO (dropping and flagging ovf when full). Geometry stats (meas_*) exist only with VIP_CAPTURE_STATS_EN.
module vip_frame_capture #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int PACK_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_start,
    input  logic              vsync,
    input  logic              href,
    input  logic              clken,
    input  logic              pix_bit,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PACK_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic              ovf,
    output logic [10:0]       meas_width,
    output logic [10:0]       meas_height
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PCW = (PACK_W > 1) ? $clog2(PACK_W) : 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = FAW + 1;
    localparam int EW  = ADDR_W + PACK_W;

    localparam logic [10:0]    HDISP     = 11'(IMG_HDISP);
    localparam logic [10:0]    VDISP     = 11'(IMG_VDISP);
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PACK_W - 1);
    localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);

    logic [1:0]        state_q, state_d;
    logic              vsync_q, href_q;
    logic [10:0]       x_q, x_d, y_q, y_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic [PACK_W-1:0] pack_q, pack_d, pack_nx;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
    logic              ovf_q, ovf_d;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [FAW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FCW-1:0]    cnt_q, cnt_d;

    logic              sof, eof, eol, capture, take, full_word, line_end;
    logic              push, pop, fifo_full, push_ok, drop;
    logic [10:0]       x_inc, y_inc, y_end;
    logic [EW-1:0]     push_ent, head;

    assign sof       = vsync & ~vsync_q;
    assign eof       = ~vsync & vsync_q;
    assign eol       = ~href & href_q;
    assign capture   = (state_q == S_CAPT);
    assign take      = capture & href & clken;
    assign full_word = take & (pcnt_q == PCNT_LAST);
    // A frame that ends with href still high closes its last line in the same cycle.
    assign line_end  = capture & (eol | (eof & href));

    assign x_inc = (take && x_q != 11'h7FF) ? x_q + 11'd1 : x_q;
    assign y_inc = (y_q != 11'h7FF) ? y_q + 11'd1 : y_q;
    assign y_end = line_end ? y_inc : y_q;

    always_comb begin
        pack_nx = pack_q;
        if (take) begin
            pack_nx[pcnt_q] = pix_bit;
        end
    end

    // Unused upper bits of pack_q are already zero, so a partial word needs no masking.
    assign push      = full_word | (line_end & ((pcnt_q != '0) | take));
    assign push_ent  = {ADDR_W'(BASE_ADDR) + widx_q, pack_nx};
    assign pop       = wr_valid & wr_ready;
    assign fifo_full = (cnt_q == FIFO_FULL);
    assign push_ok   = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pcnt_d      = pcnt_q;
        pack_d      = pack_q;
        widx_d      = widx_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        ovf_d       = ovf_q | drop;
        case (state_q)
            S_IDLE: begin
                if (cap_start) begin
                    state_d     = S_ARMED;
                    x_d         = '0;
                    y_d         = '0;
                    pcnt_d      = '0;
                    pack_d      = '0;
                    widx_d      = '0;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            S_ARMED: begin
                if (sof) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                x_d    = x_inc;
                pack_d = pack_nx;
                pcnt_d = pcnt_q + PCW'(take);
                // word_idx advances even when the FIFO drops the word, keeping addresses frame-relative.
                if (push) begin
                    pack_d = '0;
                    pcnt_d = '0;
                    widx_d = widx_q + ADDR_W'(1);
                end
                if (line_end) begin
                    x_d        = '0;
                    y_d        = y_end;
                    line_err_d = line_err_q | (x_inc != HDISP);
                end
                if (eof) begin
                    state_d     = S_DONE;
                    frame_err_d = frame_err_q | (y_end != VDISP);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push_ok ? wptr_q + FAW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + FAW'(1) : rptr_q;
        cnt_d  = cnt_q + FCW'(push_ok) - FCW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pcnt_q      <= '0;
            pack_q      <= '0;
            widx_q      <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync;
            href_q      <= href;
            x_q         <= x_d;
            y_q         <= y_d;
            pcnt_q      <= pcnt_d;
            pack_q      <= pack_d;
            widx_q      <= widx_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= push_ent;
        end
    end

    // Gate the head so the write port reads all-zero while empty (including straight after reset).
    assign head       = mem[rptr_q];
    assign wr_valid   = (cnt_q != '0);
    assign wr_addr    = wr_valid ? head[EW-1:PACK_W] : '0;
    assign wr_data    = wr_valid ? head[PACK_W-1:0] : '0;
    assign busy       = (state_q == S_ARMED) || (state_q == S_CAPT);
    assign frame_done = (state_q == S_DONE);
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign ovf        = ovf_q;

`ifdef VIP_CAPTURE_STATS_EN
    logic [10:0] meas_width_q, meas_width_d, meas_height_q, meas_height_d;

    always_comb begin
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        if (line_end) begin
            meas_width_d = x_inc;
        end
        if (capture && eof) begin
            meas_height_d = y_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_width_q  <= '0;
            meas_height_q <= '0;
        end else begin
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
        end
    end

    assign meas_width  = meas_width_q;
    assign meas_height = meas_height_q;
`else
    assign meas_width  = '0;
    assign meas_height = '0;
`endif

endmodule
